// File: rtl/decode_stage_if.sv
// decode_stage_if: fetch-side handshake, flush and decoded execute-side bundle of decode_stage
interface decode_stage_if #(parameter int XLEN = 32);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            writeReg;
    logic            writeRam;
    logic            branch;
    logic            jump;
    logic [1:0]      srcASel;
    logic            srcBSel;
    logic [1:0]      wbSel;
    logic [4:0]      aluCode;
    logic [XLEN-1:0] imm;
    logic            illegal;

    modport master (
        output flush, in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, rs1, rs2, rd, writeReg, writeRam, branch, jump,
               srcASel, srcBSel, wbSel, aluCode, imm, illegal
    );

    modport slave (
        input  flush, in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, rs1, rs2, rd, writeReg, writeRam, branch, jump,
               srcASel, srcBSel, wbSel, aluCode, imm, illegal
    );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: registered RV32I/RV64I decode with a two-entry skid buffer; DECODE_M_EXT_EN enables M-extension op decode
module decode_stage #(
    parameter int XLEN = 32
) (
    input logic           clock,
    input logic           nReset,
    decode_stage_if.slave bus
);
    localparam logic [4:0] ALU_NOP = 5'b01111;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic            write_reg;
        logic            write_ram;
        logic            branch;
        logic            jump;
        logic [1:0]      src_a_sel;
        logic            src_b_sel;
        logic [1:0]      wb_sel;
        logic [4:0]      alu_code;
        logic [XLEN-1:0] imm;
        logic            illegal;
    } entry_t;

    localparam entry_t ENTRY_RST = '{alu_code: ALU_NOP, default: '0};

    logic [31:0]     instr;
    logic [4:0]      op;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j, imm_u, imm_sh;
    entry_t          dec, out_q, skid_q;
    logic            bad, out_v, skid_v, accept, free;

    assign instr  = bus.in_instr;
    assign op     = instr[6:2];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];
    assign imm_i  = XLEN'($signed(instr[31:20]));
    assign imm_s  = XLEN'($signed({instr[31:25], instr[11:7]}));
    assign imm_b  = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
    assign imm_j  = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
    assign imm_u  = XLEN'($signed({instr[31:12], 12'b0}));
    assign imm_sh = (XLEN == 32) ? XLEN'(instr[24:20]) : XLEN'(instr[25:20]);

    // decode the incoming word; illegal encodings keep indices and PC but lose all control
    always_comb begin
        dec     = '0;
        bad     = 1'b0;
        dec.pc  = bus.in_pc;
        dec.rs1 = instr[19:15];
        dec.rs2 = instr[24:20];
        dec.rd  = instr[11:7];
        case (op)
            5'b01101: begin
                dec.write_reg = 1'b1;
                dec.src_a_sel = 2'b10;
                dec.src_b_sel = 1'b1;
                dec.imm       = imm_u;
            end
            5'b00101: begin
                dec.write_reg = 1'b1;
                dec.src_a_sel = 2'b01;
                dec.src_b_sel = 1'b1;
                dec.imm       = imm_u;
            end
            5'b11011: begin
                dec.write_reg = 1'b1;
                dec.jump      = 1'b1;
                dec.src_a_sel = 2'b01;
                dec.src_b_sel = 1'b1;
                dec.wb_sel    = 2'b10;
                dec.imm       = imm_j;
            end
            5'b11001: begin
                dec.write_reg = 1'b1;
                dec.jump      = 1'b1;
                dec.src_b_sel = 1'b1;
                dec.wb_sel    = 2'b10;
                dec.imm       = imm_i;
                bad           = f3 != 3'b000;
            end
            5'b11000: begin
                dec.branch   = 1'b1;
                dec.alu_code = {2'b01, f3};
                dec.imm      = imm_b;
                bad          = f3[2:1] == 2'b01;
            end
            5'b00000: begin
                dec.write_reg = 1'b1;
                dec.src_b_sel = 1'b1;
                dec.wb_sel    = 2'b01;
                dec.imm       = imm_i;
            end
            5'b01000: begin
                dec.write_ram = 1'b1;
                dec.src_b_sel = 1'b1;
                dec.imm       = imm_s;
            end
            5'b00100: begin
                dec.write_reg = 1'b1;
                dec.src_b_sel = 1'b1;
                dec.alu_code  = (f3 == 3'b011) ? 5'b01010 : {1'b0, f3 == 3'b101 && instr[30], f3};
                dec.imm       = (f3[1:0] == 2'b01) ? imm_sh : imm_i;
            end
            5'b01100: begin
                if (f7 == 7'b0000001) begin
`ifdef DECODE_M_EXT_EN
                    dec.write_reg = 1'b1;
                    dec.alu_code  = {2'b10, f3};
`else
                    bad = 1'b1;
`endif
                end else begin
                    dec.write_reg = 1'b1;
                    dec.alu_code  = (f3 == 3'b011) ? 5'b01010 : {1'b0, f7[5], f3};
                end
            end
            default: bad = 1'b1;
        endcase
        if (bad || instr[1:0] != 2'b11) begin
            dec.write_reg = 1'b0;
            dec.write_ram = 1'b0;
            dec.branch    = 1'b0;
            dec.jump      = 1'b0;
            dec.src_a_sel = 2'b00;
            dec.src_b_sel = 1'b0;
            dec.wb_sel    = 2'b00;
            dec.alu_code  = ALU_NOP;
            dec.imm       = '0;
            dec.illegal   = 1'b1;
        end
    end

    // in_ready comes only from registered skid state, so back-pressure never reaches fetch combinationally
    assign bus.in_ready = !skid_v && !bus.flush;
    assign accept       = bus.in_valid && bus.in_ready;
    assign free         = !out_v || bus.out_ready;

    // occupancy: a skid entry always refills the output first; accept is impossible while the skid is full
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            out_v  <= 1'b0;
            skid_v <= 1'b0;
        end else if (bus.flush) begin
            out_v  <= 1'b0;
            skid_v <= 1'b0;
        end else if (free) begin
            out_v  <= skid_v || accept;
            skid_v <= 1'b0;
        end else if (accept) begin
            skid_v <= 1'b1;
        end
    end

    // payload: output register only changes when it is free, keeping held fields stable
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            out_q  <= ENTRY_RST;
            skid_q <= ENTRY_RST;
        end else begin
            if (free && (skid_v || accept))
                out_q <= skid_v ? skid_q : dec;
            if (!free && accept)
                skid_q <= dec;
        end
    end

    assign bus.out_valid = out_v;
    assign bus.out_pc    = out_q.pc;
    assign bus.rs1       = out_q.rs1;
    assign bus.rs2       = out_q.rs2;
    assign bus.rd        = out_q.rd;
    assign bus.writeReg  = out_q.write_reg;
    assign bus.writeRam  = out_q.write_ram;
    assign bus.branch    = out_q.branch;
    assign bus.jump      = out_q.jump;
    assign bus.srcASel   = out_q.src_a_sel;
    assign bus.srcBSel   = out_q.src_b_sel;
    assign bus.wbSel     = out_q.wb_sel;
    assign bus.aluCode   = out_q.alu_code;
    assign bus.imm       = out_q.imm;
    assign bus.illegal   = out_q.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed and randomized checks of decode_stage against a queue-based reference model
module tb_decode_stage;
    logic clock;
    logic nReset;
    int   n_vec = 0;
    int   n_err = 0;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [8:0]  ctl;
        logic [4:0]  alu;
        logic [31:0] imm;
        logic        ill;
    } exp_t;

    exp_t exp_q[$];

    decode_stage_if #(.XLEN(32)) bus ();
    decode_stage #(.XLEN(32)) dut (.clock(clock), .nReset(nReset), .bus(bus));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // control word: {writeReg, writeRam, branch, jump, srcASel, srcBSel, wbSel}
    function automatic exp_t ref_decode(input logic [31:0] i, input logic [31:0] pc);
        exp_t        e;
        logic [2:0]  f3;
        logic        ok;
        logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;
        f3    = i[14:12];
        ok    = 1'b1;
        imm_i = $signed(i) >>> 20;
        imm_s = (imm_i & ~32'h1f) | 32'(i[11:7]);
        imm_u = i & 32'hfffff000;
        imm_b = (i[31] ? 32'hfffff000 : 32'h0) | (32'(i[7]) << 11) | (32'(i[30:25]) << 5) | (32'(i[11:8]) << 1);
        imm_j = (i[31] ? 32'hfff00000 : 32'h0) | (32'(i[19:12]) << 12) | (32'(i[20]) << 11) | (32'(i[30:21]) << 1);
        e.pc  = pc;
        e.rs1 = i[19:15];
        e.rs2 = i[24:20];
        e.rd  = i[11:7];
        e.ctl = '0;
        e.alu = 5'd0;
        e.imm = '0;
        e.ill = 1'b0;
        case (i[6:0])
            7'b0110111: begin e.ctl = 9'b1000_10_1_00; e.imm = imm_u; end
            7'b0010111: begin e.ctl = 9'b1000_01_1_00; e.imm = imm_u; end
            7'b1101111: begin e.ctl = 9'b1001_01_1_10; e.imm = imm_j; end
            7'b1100111: begin e.ctl = 9'b1001_00_1_10; e.imm = imm_i; ok = (f3 == 3'd0); end
            7'b1100011: begin e.ctl = 9'b0010_00_0_00; e.imm = imm_b; e.alu = 5'd8 + 5'(f3); ok = (f3 != 3'd2) && (f3 != 3'd3); end
            7'b0000011: begin e.ctl = 9'b1000_00_1_01; e.imm = imm_i; end
            7'b0100011: begin e.ctl = 9'b0100_00_1_00; e.imm = imm_s; end
            7'b0010011: begin
                e.ctl = 9'b1000_00_1_00;
                e.alu = (f3 == 3'd3) ? 5'd10 : (f3 == 3'd5 && i[30]) ? 5'd13 : 5'(f3);
                e.imm = (f3 == 3'd1 || f3 == 3'd5) ? 32'(i[24:20]) : imm_i;
            end
            7'b0110011: begin
                if (i[31:25] == 7'd1) begin
`ifdef DECODE_M_EXT_EN
                    e.ctl = 9'b1000_00_0_00;
                    e.alu = 5'd16 + 5'(f3);
`else
                    ok = 1'b0;
`endif
                end else begin
                    e.ctl = 9'b1000_00_0_00;
                    e.alu = (f3 == 3'd3) ? 5'd10 : (i[30] ? 5'd8 : 5'd0) + 5'(f3);
                end
            end
            default: ok = 1'b0;
        endcase
        if (!ok) begin
            e.ctl = '0;
            e.alu = 5'd15;
            e.imm = '0;
            e.ill = 1'b1;
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        int          k;
        r = $urandom;
        k = $urandom_range(0, 11);
        case (k)
            0: r[6:0] = 7'b0110111;
            1: r[6:0] = 7'b0010111;
            2: r[6:0] = 7'b1101111;
            3: r[6:0] = 7'b1100111;
            4: r[6:0] = 7'b1100011;
            5: r[6:0] = 7'b0000011;
            6: r[6:0] = 7'b0100011;
            7: r[6:0] = 7'b0010011;
            8: r = {1'b0, r[30], 5'b0, r[24:7], 7'b0110011};
            9: r = {7'b0000001, r[24:7], 7'b0110011};
            10: r[1:0] = 2'b11;
            default: ;
        endcase
        return r;
    endfunction

    // one cycle: drive after the edge, compare at the falling edge, advance the model at the rising edge
    task automatic step(input bit v, input logic [31:0] ins, input logic [31:0] pc, input bit ordy, input bit fl);
        bit   acc, drn;
        exp_t e;
        bus.in_valid  = v;
        bus.in_instr  = ins;
        bus.in_pc     = pc;
        bus.out_ready = ordy;
        bus.flush     = fl;
        @(negedge clock);
        check("out_valid", 64'(bus.out_valid), 64'(exp_q.size() > 0));
        check("in_ready", 64'(bus.in_ready), 64'(exp_q.size() < 2 && !fl));
        if (exp_q.size() > 0) begin
            e = exp_q[0];
            check("out_pc", 64'(bus.out_pc), 64'(e.pc));
            check("rs1", 64'(bus.rs1), 64'(e.rs1));
            check("rs2", 64'(bus.rs2), 64'(e.rs2));
            check("rd", 64'(bus.rd), 64'(e.rd));
            check("ctl", 64'({bus.writeReg, bus.writeRam, bus.branch, bus.jump, bus.srcASel, bus.srcBSel, bus.wbSel}), 64'(e.ctl));
            check("aluCode", 64'(bus.aluCode), 64'(e.alu));
            check("illegal", 64'(bus.illegal), 64'(e.ill));
            if (!e.ill)
                check("imm", 64'(bus.imm), 64'(e.imm));
        end
        acc = v && exp_q.size() < 2 && !fl;
        drn = exp_q.size() > 0 && ordy;
        @(posedge clock);
        if (fl) begin
            exp_q.delete();
        end else begin
            if (drn)
                void'(exp_q.pop_front());
            if (acc)
                exp_q.push_back(ref_decode(ins, pc));
        end
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
        check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        check({tag, "_aluCode"}, 64'(bus.aluCode), 64'h0f);
        check({tag, "_illegal"}, 64'(bus.illegal), 64'd0);
        check({tag, "_ctl"}, 64'({bus.writeReg, bus.writeRam, bus.branch, bus.jump, bus.srcASel, bus.srcBSel, bus.wbSel}), 64'd0);
        check({tag, "_imm"}, 64'(bus.imm), 64'd0);
        check({tag, "_out_pc"}, 64'(bus.out_pc), 64'd0);
        check({tag, "_rd"}, 64'(bus.rd), 64'd0);
    endtask

    initial begin
        nReset        = 1'b0;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_instr  = '0;
        bus.in_pc     = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check_idle("reset");
        @(negedge clock);
        nReset = 1'b1;
        @(posedge clock);
        #1;

        step(1, 32'h123450B7, 32'h0000_1000, 1, 0);
        check("lui_valid", 64'(bus.out_valid), 64'd1);
        check("lui_rd", 64'(bus.rd), 64'd1);
        check("lui_imm", 64'(bus.imm), 64'h12345000);
        check("lui_writeReg", 64'(bus.writeReg), 64'd1);
        check("lui_srcASel", 64'(bus.srcASel), 64'd2);
        step(0, 32'h0, 32'h0, 1, 0);

        step(1, 32'h00500093, 32'h0000_2000, 0, 0);
        step(1, 32'h00A00113, 32'h0000_2004, 0, 0);
        check("bp_in_ready", 64'(bus.in_ready), 64'd0);
        step(1, 32'h00F00193, 32'h0000_2008, 0, 0);
        check("bp_out_pc_held", 64'(bus.out_pc), 64'h2000);
        repeat (3) step(0, 32'h0, 32'h0, 1, 0);

        step(1, 32'hFE000EE3, 32'h0000_3000, 1, 0);
        check("beq_branch", 64'(bus.branch), 64'd1);
        check("beq_aluCode", 64'(bus.aluCode), 64'h08);
        check("beq_imm", 64'(bus.imm), 64'hFFFFFFFC);
        check("beq_illegal", 64'(bus.illegal), 64'd0);
        step(0, 32'h0, 32'h0, 1, 0);

        step(1, 32'h00100093, 32'h0000_4000, 0, 0);
        step(1, 32'h00200113, 32'h0000_4004, 0, 0);
        step(1, 32'h00300193, 32'h0000_4008, 0, 1);
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check("flush_out_valid", 64'(bus.out_valid), 64'd0);
        check("flush_in_ready", 64'(bus.in_ready), 64'd1);
        repeat (2) step(0, 32'h0, 32'h0, 1, 0);

        step(1, 32'h02208033, 32'h0000_5000, 1, 0);
`ifdef DECODE_M_EXT_EN
        check("mul_aluCode", 64'(bus.aluCode), 64'h10);
        check("mul_illegal", 64'(bus.illegal), 64'd0);
        check("mul_writeReg", 64'(bus.writeReg), 64'd1);
`else
        check("mul_aluCode", 64'(bus.aluCode), 64'h0f);
        check("mul_illegal", 64'(bus.illegal), 64'd1);
        check("mul_writeReg", 64'(bus.writeReg), 64'd0);
`endif
        step(0, 32'h0, 32'h0, 1, 0);

        step(1, 32'h00400093, 32'h0000_6000, 0, 0);
        step(1, 32'h00800113, 32'h0000_6004, 0, 0);
        bus.in_valid = 1'b0;
        #2 nReset = 1'b0;
        #1;
        check_idle("async_reset");
        exp_q.delete();
        @(negedge clock);
        nReset = 1'b1;
        @(posedge clock);
        #1;

        for (int n = 0; n < 1500; n++)
            step($urandom_range(0, 3) != 0, rand_instr(), $urandom & 32'hFFFF_FFFC,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0);
        repeat (3) step(0, 32'h0, 32'h0, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
